// File: rtl/ex_stage_pkg.sv
// Shared operator/category codes, divider state encoding and a small helper
// used by the execute stage and its divider.
package ex_stage_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int OP_W   = 8;
  localparam int CAT_W  = 3;

  localparam logic [OP_W-1:0] OP_AND  = 8'b00100100;
  localparam logic [OP_W-1:0] OP_OR   = 8'b00100101;
  localparam logic [OP_W-1:0] OP_XOR  = 8'b00100110;
  localparam logic [OP_W-1:0] OP_NOR  = 8'b00100111;
  localparam logic [OP_W-1:0] OP_SLL  = 8'b01111100;
  localparam logic [OP_W-1:0] OP_SRL  = 8'b00000010;
  localparam logic [OP_W-1:0] OP_SRA  = 8'b00000011;
  localparam logic [OP_W-1:0] OP_ADDU = 8'b00100001;
  localparam logic [OP_W-1:0] OP_SUBU = 8'b00100011;
  localparam logic [OP_W-1:0] OP_SLT  = 8'b00101010;
  localparam logic [OP_W-1:0] OP_SLTU = 8'b00101011;
  localparam logic [OP_W-1:0] OP_DIV  = 8'b00011010;
  localparam logic [OP_W-1:0] OP_DIVU = 8'b00011011;

  localparam logic [CAT_W-1:0] CAT_NOP   = 3'b000;
  localparam logic [CAT_W-1:0] CAT_LOGIC = 3'b001;
  localparam logic [CAT_W-1:0] CAT_SHIFT = 3'b010;
  localparam logic [CAT_W-1:0] CAT_ARITH = 3'b100;

  typedef enum logic [1:0] {
    DIV_IDLE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_RUN     = 2'b10,
    DIV_DONE    = 2'b11
  } div_state_e;

  // Two's-complement magnitude; 0x80000000 maps to itself, which is the
  // correct unsigned magnitude.
  function automatic logic [DATA_W-1:0] abs32(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? -v : v;
  endfunction

endpackage

// File: rtl/ex_divider.sv
// Radix-2 restoring divider: one quotient bit per cycle over 32 cycles,
// with a divide-by-zero shortcut and flush (annul) support.
module ex_divider
  import ex_stage_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              signed_div,
  input  logic              annul,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  div_state_e        r_state, w_next;
  logic [4:0]        r_count;
  logic [DATA_W-1:0] r_quot, r_rem, r_divisor;
  logic              r_neg_q, r_neg_r;

  logic [DATA_W:0]   w_shifted, w_diff;
  logic              w_fits;
  logic [DATA_W-1:0] w_quot_step, w_rem_step;

  // Bit 32 of the 33-bit difference is the borrow: set when the trial
  // subtraction would go negative.
  assign w_shifted   = {r_rem, r_quot[DATA_W-1]};
  assign w_diff      = w_shifted - {1'b0, r_divisor};
  assign w_fits      = ~w_diff[DATA_W];
  assign w_rem_step  = w_fits ? w_diff[DATA_W-1:0] : w_shifted[DATA_W-1:0];
  assign w_quot_step = {r_quot[DATA_W-2:0], w_fits};

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    if (reset) r_state <= DIV_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    // NOTE: defaults first so no branch leaves a signal unassigned (no inferred latch).
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      DIV_IDLE: begin
        if (start && !annul) begin
          busy   = 1'b1;
          w_next = (divisor == '0) ? DIV_BY_ZERO : DIV_RUN;
        end
      end
      DIV_BY_ZERO: begin
        if (annul) w_next = DIV_IDLE;
        else begin
          busy   = 1'b1;
          w_next = DIV_DONE;
        end
      end
      DIV_RUN: begin
        if (annul) w_next = DIV_IDLE;
        else begin
          busy = 1'b1;
          if (r_count == 5'd31) w_next = DIV_DONE;
        end
      end
      DIV_DONE: begin
        done   = 1'b1;
        w_next = DIV_IDLE;
      end
      default: w_next = DIV_IDLE;
    endcase
    if (reset) begin
      busy = 1'b0;
      done = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: datapath registers are cleared too, so a reset mid-division leaves nothing stale.
    if (reset) begin
      r_count   <= '0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (start && !annul) begin
            r_quot    <= signed_div ? abs32(dividend) : dividend;
            r_divisor <= signed_div ? abs32(divisor)  : divisor;
            r_rem     <= '0;
            r_count   <= '0;
            r_neg_q   <= signed_div & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
            r_neg_r   <= signed_div & dividend[DATA_W-1];
          end
        end
        DIV_BY_ZERO: begin
          r_quot <= '0;
          r_rem  <= '0;
        end
        DIV_RUN: begin
          r_count <= r_count + 5'd1;
          // The last step also applies the sign fix-up.
          if (r_count == 5'd31) begin
            r_quot <= r_neg_q ? -w_quot_step : w_quot_step;
            r_rem  <= r_neg_r ? -w_rem_step  : w_rem_step;
          end else begin
            r_quot <= w_quot_step;
            r_rem  <= w_rem_step;
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient  = done ? r_quot : '0;
  assign remainder = done ? r_rem  : '0;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: combinational logic/shift/arithmetic unit with category
// muxing, plus the multi-cycle divider that drives HI/LO and the stall.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [OP_W-1:0]   ex_operator,
  input  logic [CAT_W-1:0]  ex_category,
  input  logic [DATA_W-1:0] ex_operand1,
  input  logic [DATA_W-1:0] ex_operand2,
  input  logic [ADDR_W-1:0] ex_write_addr,
  input  logic              ex_write_enable,
  input  logic              annul,
  output logic [ADDR_W-1:0] result_addr,
  output logic              result_enable,
  output logic [DATA_W-1:0] result_data,
  output logic              hilo_enable,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              stall_request
);

  logic [DATA_W-1:0] w_logic, w_shift, w_arith, w_result;
  logic [4:0]        w_amount;
  logic              w_is_div;

  assign w_amount = ex_operand1[4:0];
  assign w_is_div = (ex_operator == OP_DIV) || (ex_operator == OP_DIVU);

  always_comb begin
    w_logic = '0;
    w_shift = '0;
    w_arith = '0;
    case (ex_operator)
      OP_AND:  w_logic = ex_operand1 & ex_operand2;
      OP_OR:   w_logic = ex_operand1 | ex_operand2;
      OP_XOR:  w_logic = ex_operand1 ^ ex_operand2;
      OP_NOR:  w_logic = ~(ex_operand1 | ex_operand2);
      OP_SLL:  w_shift = ex_operand2 << w_amount;
      OP_SRL:  w_shift = ex_operand2 >> w_amount;
      OP_SRA:  w_shift = $unsigned($signed(ex_operand2) >>> w_amount);
      OP_ADDU: w_arith = ex_operand1 + ex_operand2;
      OP_SUBU: w_arith = ex_operand1 - ex_operand2;
      OP_SLT:  w_arith = {31'd0, $signed(ex_operand1) < $signed(ex_operand2)};
      OP_SLTU: w_arith = {31'd0, ex_operand1 < ex_operand2};
      default: ;
    endcase
  end

  always_comb begin
    w_result = '0;
    case (ex_category)
      CAT_LOGIC: w_result = w_logic;
      CAT_SHIFT: w_result = w_shift;
      CAT_ARITH: w_result = w_arith;
      default:   w_result = '0;
    endcase
  end

  assign result_data   = (reset || w_is_div) ? '0 : w_result;
  assign result_addr   = reset ? '0 : ex_write_addr;
  assign result_enable = reset ? 1'b0 : ex_write_enable;

  ex_divider u_divider (
    .clock      (clock),
    .reset      (reset),
    .start      (w_is_div),
    .signed_div (ex_operator == OP_DIV),
    .annul      (annul),
    .dividend   (ex_operand1),
    .divisor    (ex_operand2),
    .busy       (stall_request),
    .done       (hilo_enable),
    .quotient   (lo),
    .remainder  (hi)
  );

endmodule
